// File: rtl/c7bifu_pkg.sv
// c7bifu_pkg: shared fetch FSM encoding and fetch granule for the c7bifu blocks.
package c7bifu_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD, ST_DRAIN} state_t;
  localparam logic [31:0] FETCH_BYTES = 32'd8;
endpackage

// File: rtl/c7bifu_ifetch.sv
// c7bifu_ifetch: single-outstanding 64-bit instruction fetcher between the bus and the instruction queue.
module c7bifu_ifetch
  import c7bifu_pkg::*;
#(
  parameter bit          REQ_GATE_ON_FULL = 1'b1,
  parameter logic [31:0] RESET_ADDR       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [31:0] start_addr,
  input  logic        iq_full,
  output logic        ifu_req_vld,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_req_rdy,
  input  logic        biu_rsp_vld,
  input  logic [63:0] biu_rsp_data,
  output logic        data_vld,
  output logic [31:0] data_addr,
  output logic [63:0] data
);
  state_t      r_state, w_next;
  logic        r_started;
  logic [31:0] r_pc, r_addr;
  logic [63:0] r_data;
  logic        w_gate, w_hs, w_consume;
  logic [31:0] w_base;
  assign w_gate       = REQ_GATE_ON_FULL && iq_full;
  assign w_hs         = (r_state == ST_REQ) && ifu_req_rdy;
  assign w_consume    = (r_state == ST_HOLD) && !iq_full;
  assign w_base       = start_addr & 32'hFFFF_FFF8;
  assign ifu_req_vld  = (r_state == ST_REQ);
  assign ifu_req_addr = ifu_req_vld ? r_pc : 32'h0;
  assign data_vld     = (r_state == ST_HOLD);
  assign data_addr    = r_addr;
  assign data         = r_data;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  w_next = (flush || r_started) && !w_gate ? ST_REQ : ST_IDLE;
      ST_REQ:   w_next = w_hs ? (flush ? ST_DRAIN : ST_WAIT) : ST_REQ;
      ST_WAIT:  w_next = flush ? (biu_rsp_vld ? ST_REQ : ST_DRAIN) : (biu_rsp_vld ? ST_HOLD : ST_WAIT);
      ST_HOLD:  w_next = flush ? (w_gate ? ST_IDLE : ST_REQ) : (iq_full ? ST_HOLD : ST_REQ);
      ST_DRAIN: w_next = biu_rsp_vld ? ST_REQ : ST_DRAIN;
      default:  w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end
  // r_started remembers a flush that was parked in IDLE while the queue was full
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_started <= 1'b0;
      r_pc      <= RESET_ADDR;
      r_addr    <= 32'h0;
      r_data    <= 64'h0;
    end else begin
      if (flush) r_started <= 1'b1;
      r_pc <= flush ? w_base : w_consume ? r_pc + FETCH_BYTES : r_pc;
      if (r_state == ST_WAIT && biu_rsp_vld && !flush) begin
        r_addr <= r_pc;
        r_data <= biu_rsp_data;
      end
    end
  end
endmodule

// File: tb/tb_c7bifu_ifetch.sv
// tb_c7bifu_ifetch: cycle-table directed test of the fetcher plus reset corner sequences.
module tb_c7bifu_ifetch;
  logic        clk = 1'b0;
  logic        resetn, flush, iq_full, ifu_req_rdy, biu_rsp_vld;
  logic [31:0] start_addr;
  logic [63:0] biu_rsp_data;
  logic        ifu_req_vld, data_vld;
  logic [31:0] ifu_req_addr, data_addr;
  logic [63:0] data;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic        f;
    logic [31:0] sa;
    logic        full, rdy, rv;
    logic [63:0] rd;
    logic        evld;
    logic [31:0] eaddr;
    logic        edv;
    logic [31:0] edaddr;
    logic [63:0] edat;
  } vec_t;
  vec_t v[$];
  localparam logic [63:0] D0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D2 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] D3 = 64'hDDDD_EEEE_FFFF_0000;
  localparam logic [63:0] D4 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D5 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DX = 64'hDEAD_BEEF_DEAD_BEEF;

  c7bifu_ifetch dut (
    .clk(clk), .resetn(resetn), .flush(flush), .start_addr(start_addr), .iq_full(iq_full),
    .ifu_req_vld(ifu_req_vld), .ifu_req_addr(ifu_req_addr), .ifu_req_rdy(ifu_req_rdy),
    .biu_rsp_vld(biu_rsp_vld), .biu_rsp_data(biu_rsp_data),
    .data_vld(data_vld), .data_addr(data_addr), .data(data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic f, input logic [31:0] sa, input logic full, input logic rdy,
                     input logic rv, input logic [63:0] rd, input logic evld, input logic [31:0] eaddr,
                     input logic edv, input logic [31:0] edaddr, input logic [63:0] edat);
    vec_t r;
    r.f = f; r.sa = sa; r.full = full; r.rdy = rdy; r.rv = rv; r.rd = rd;
    r.evld = evld; r.eaddr = eaddr; r.edv = edv; r.edaddr = edaddr; r.edat = edat;
    v.push_back(r);
  endtask

  task automatic drive(input logic f, input logic [31:0] sa, input logic full, input logic rdy,
                       input logic rv, input logic [63:0] rd);
    @(negedge clk);
    flush = f; start_addr = sa; iq_full = full; ifu_req_rdy = rdy; biu_rsp_vld = rv; biu_rsp_data = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".req_vld"}, 64'(ifu_req_vld), 64'h0);
    check({tag, ".req_addr"}, 64'(ifu_req_addr), 64'h0);
    check({tag, ".data_vld"}, 64'(data_vld), 64'h0);
    check({tag, ".data_addr"}, 64'(data_addr), 64'h0);
    check({tag, ".data"}, data, 64'h0);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; start_addr = '0; iq_full = 1'b0;
    ifu_req_rdy = 1'b0; biu_rsp_vld = 1'b0; biu_rsp_data = '0;
    //  f  sa            full rdy rv rd   | req addr          dv daddr         data
    add(0, 32'h0,        0,  0,  0, '0,    0, 32'h0,         0, 32'h0,        '0);
    add(1, 32'h1004,     0,  0,  0, '0,    1, 32'h1000,      0, 32'h0,        '0);
    add(0, 32'h0,        0,  0,  0, '0,    1, 32'h1000,      0, 32'h0,        '0);
    add(0, 32'h0,        0,  1,  0, '0,    0, 32'h0,         0, 32'h0,        '0);
    add(0, 32'h0,        0,  0,  0, '0,    0, 32'h0,         0, 32'h0,        '0);
    add(0, 32'h0,        0,  0,  1, D0,    0, 32'h0,         1, 32'h1000,     D0);
    add(0, 32'h0,        1,  0,  0, '0,    0, 32'h0,         1, 32'h1000,     D0);
    add(0, 32'h0,        0,  0,  0, '0,    1, 32'h1008,      0, 32'h1000,     D0);
    add(0, 32'h0,        0,  1,  0, '0,    0, 32'h0,         0, 32'h1000,     D0);
    add(0, 32'h0,        0,  0,  1, D1,    0, 32'h0,         1, 32'h1008,     D1);
    for (int i = 0; i < 5; i++)
      add(0, 32'h0,      1,  0,  0, '0,    0, 32'h0,         1, 32'h1008,     D1);
    add(0, 32'h0,        0,  0,  0, '0,    1, 32'h1010,      0, 32'h1008,     D1);
    // flush in WAIT, response three cycles later is dropped
    add(0, 32'h0,        0,  1,  0, '0,    0, 32'h0,         0, 32'h1008,     D1);
    add(1, 32'h2000,     0,  0,  0, '0,    0, 32'h0,         0, 32'h1008,     D1);
    add(0, 32'h0,        0,  0,  0, '0,    0, 32'h0,         0, 32'h1008,     D1);
    add(0, 32'h0,        0,  0,  0, '0,    0, 32'h0,         0, 32'h1008,     D1);
    add(0, 32'h0,        0,  0,  1, DX,    1, 32'h2000,      0, 32'h1008,     D1);
    // flush with REQ handshake
    add(1, 32'h3000,     0,  1,  0, '0,    0, 32'h0,         0, 32'h1008,     D1);
    add(0, 32'h0,        0,  0,  1, DX,    1, 32'h3000,      0, 32'h1008,     D1);
    add(0, 32'h0,        0,  1,  0, '0,    0, 32'h0,         0, 32'h1008,     D1);
    add(0, 32'h0,        0,  0,  1, D2,    0, 32'h0,         1, 32'h3000,     D2);
    add(0, 32'h0,        0,  0,  0, '0,    1, 32'h3008,      0, 32'h3000,     D2);
    add(0, 32'h0,        0,  1,  0, '0,    0, 32'h0,         0, 32'h3000,     D2);
    // flush coincident with response
    add(1, 32'h4000,     0,  0,  1, DX,    1, 32'h4000,      0, 32'h3000,     D2);
    add(0, 32'h0,        0,  1,  0, '0,    0, 32'h0,         0, 32'h3000,     D2);
    add(0, 32'h0,        0,  0,  1, D3,    0, 32'h0,         1, 32'h4000,     D3);
    // flush in HOLD, then wrap at the top of the address space
    add(1, 32'hFFFF_FFFC, 0, 0,  0, '0,    1, 32'hFFFF_FFF8, 0, 32'h4000,     D3);
    add(0, 32'h0,        0,  1,  0, '0,    0, 32'h0,         0, 32'h4000,     D3);
    add(0, 32'h0,        0,  0,  1, D4,    0, 32'h0,         1, 32'hFFFF_FFF8, D4);
    add(0, 32'h0,        0,  0,  0, '0,    1, 32'h0,         0, 32'hFFFF_FFF8, D4);
    // stray response in REQ is ignored
    add(0, 32'h0,        0,  0,  1, DX,    1, 32'h0,         0, 32'hFFFF_FFF8, D4);
    add(0, 32'h0,        0,  1,  0, '0,    0, 32'h0,         0, 32'hFFFF_FFF8, D4);
    add(0, 32'h0,        0,  0,  1, D5,    0, 32'h0,         1, 32'h0,        D5);
    // flush in HOLD while queue full parks until iq_full drops
    add(1, 32'h5000,     1,  0,  0, '0,    0, 32'h0,         0, 32'h0,        D5);
    add(0, 32'h0,        1,  0,  0, '0,    0, 32'h0,         0, 32'h0,        D5);
    add(0, 32'h0,        0,  0,  0, '0,    1, 32'h5000,      0, 32'h0,        D5);
    // repeated flush in DRAIN only retargets
    add(0, 32'h0,        0,  1,  0, '0,    0, 32'h0,         0, 32'h0,        D5);
    add(1, 32'h6000,     0,  0,  0, '0,    0, 32'h0,         0, 32'h0,        D5);
    add(1, 32'h7000,     0,  0,  0, '0,    0, 32'h0,         0, 32'h0,        D5);
    add(0, 32'h0,        0,  0,  1, DX,    1, 32'h7000,      0, 32'h0,        D5);
    add(0, 32'h0,        0,  1,  0, '0,    0, 32'h0,         0, 32'h0,        D5);

    repeat (2) @(posedge clk);
    #1 check_zero("in_reset");
    @(negedge clk) resetn = 1'b1;
    foreach (v[i]) begin
      drive(v[i].f, v[i].sa, v[i].full, v[i].rdy, v[i].rv, v[i].rd);
      check($sformatf("row%0d.req_vld", i), 64'(ifu_req_vld), 64'(v[i].evld));
      check($sformatf("row%0d.req_addr", i), 64'(ifu_req_addr), 64'(v[i].eaddr));
      check($sformatf("row%0d.data_vld", i), 64'(data_vld), 64'(v[i].edv));
      check($sformatf("row%0d.data_addr", i), 64'(data_addr), 64'(v[i].edaddr));
      check($sformatf("row%0d.data", i), data, v[i].edat);
    end
    // DUT is in WAIT here: asynchronous reset, then a late response
    @(negedge clk);
    ifu_req_rdy = 1'b0;
    #2 resetn = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk) resetn = 1'b1;
    drive(0, 32'h0, 0, 0, 1, DX);
    check_zero("late_rsp");
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, 0, 0, 0, '0);
      check_zero($sformatf("post_reset%0d", i));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/c7bifu_ifetch.md
C7BIFU_IFETCH -- requirements
Module: c7bifu_ifetch

Interface
REQ-001 Parameter REQ_GATE_ON_FULL, default 1: when 1, the block SHALL NOT leave IDLE/HOLD to issue a new request while iq_full=1.
REQ-002 Parameter RESET_ADDR, default 32'h0000_0000: SHALL be the fetch_pc value after reset.
REQ-003 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 resetn  in  1  reset, SHALL be asynchronous and active-low.
REQ-005 flush  in  1  redirect: discard everything in flight and restart fetching at start_addr.
REQ-006 start_addr  in  32  redirect target, sampled only when flush=1.
REQ-007 iq_full  in  1  downstream instruction queue cannot accept a 64-bit beat.
REQ-008 ifu_req_vld  out  1  bus read request valid.
REQ-009 ifu_req_addr  out  32  bus read address, always 8-byte aligned ([2:0]=0).
REQ-010 ifu_req_rdy  in  1  bus accepts the request when ifu_req_vld and ifu_req_rdy are both 1.
REQ-011 biu_rsp_vld  in  1  read data return, one pulse per accepted request.
REQ-012 biu_rsp_data  in  64  returned data, [31:0] = lower address word.
REQ-013 data_vld  out  1  beat valid to the instruction queue; the beat is consumed when data_vld=1 and iq_full=0.
REQ-014 data_addr  out  32  aligned address of the beat.
REQ-015 data  out  64  beat payload.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, REQ, WAIT, HOLD and DRAIN, with at most one outstanding bus request.
REQ-017 IDLE: the block SHALL stay idle after reset until the first flush.
REQ-018 Any state on flush: fetch_pc SHALL load {start_addr[31:3],3'b000}.
REQ-019 REQ: ifu_req_vld=1 and ifu_req_addr=fetch_pc; on handshake the FSM SHALL move to WAIT.
REQ-020 WAIT: on biu_rsp_vld the FSM SHALL capture biu_rsp_data and fetch_pc into the data/data_addr registers and move to HOLD, so data_vld rises exactly 1 cycle after biu_rsp_vld.
REQ-021 HOLD: data_vld=1, and data/data_addr SHALL stay stable until consumed.
REQ-022 HOLD on consume: fetch_pc SHALL advance by 8, modulo 2^32 (32'hFFFF_FFF8 -> 32'h0), and the FSM SHALL go to REQ, or stay in an idle-hold until iq_full=0 when REQ_GATE_ON_FULL=1.
REQ-023 Flush in IDLE or HOLD: the FSM SHALL go to REQ and drop any held beat; data_vld SHALL be 0 in the next cycle.
REQ-024 Flush in REQ: if the handshake occurs in the same cycle, the FSM SHALL go to DRAIN; otherwise it SHALL stay in REQ presenting the new address.
REQ-025 Flush in WAIT: if biu_rsp_vld is 1 in the same cycle, the response SHALL be discarded and the FSM SHALL go to REQ; otherwise it SHALL go to DRAIN.
REQ-026 DRAIN: no request is issued; the next biu_rsp_vld SHALL be discarded and the FSM SHALL go to REQ. A further flush in DRAIN only updates fetch_pc.
REQ-027 A biu_rsp_vld in IDLE, REQ or HOLD is a protocol error and SHALL be ignored.
REQ-028 Flush SHALL take priority over every other event in the same cycle.
REQ-029 ifu_req_vld SHALL be driven only from state, with no combinational path from ifu_req_rdy.

Reset
REQ-030 While resetn=0: state=IDLE, fetch_pc=RESET_ADDR, ifu_req_vld=0, ifu_req_addr=0, data_vld=0, data=0, data_addr=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the outstanding request; any later response SHALL be ignored because the FSM is in IDLE.

Structure
REQ-032 The FSM state encoding and the constant FETCH_BYTES=8 SHALL live in the shared package c7bifu_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the response holding register is inline.

Verification
REQ-034 Reset, then flush with start_addr=0x1004: the bench SHALL see ifu_req_addr=0x1000, then after responses D0/D1 see data_addr 0x1000 then 0x1008, with data_vld 1 cycle after each biu_rsp_vld.
REQ-035 iq_full=1 for 5 cycles while in HOLD: data_vld SHALL stay 1 with data/data_addr unchanged, no new request is issued, and fetch_pc advances by exactly 8 once iq_full=0.
REQ-036 Flush to 0x2000 while in WAIT, with the response arriving 3 cycles later: the response SHALL be dropped (no data_vld), and the next ifu_req_addr SHALL be 0x2000.
REQ-037 Flush coincident with biu_rsp_vld, and separately with the REQ handshake: no stale beat SHALL be emitted, and the first beat after the flush SHALL carry the new address.
REQ-038 fetch_pc=0xFFFF_FFF8 consumed: the next ifu_req_addr SHALL be 0x0000_0000.
REQ-039 resetn pulsed low during WAIT, with the response arriving afterwards: the FSM SHALL be in IDLE, all outputs 0, and data_vld SHALL never assert.
